// File: rtl/spi_mult_master_pkg.sv
// Shared types and sizing helpers for the multiplier-peripheral SPI master.
package spi_mult_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEAD = 3'd1,
    ST_SEND = 3'd2,
    ST_GAP  = 3'd3,
    ST_RECV = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  function automatic int max3(input int x, input int y, input int z);
    int m;
    m = (x > y) ? x : y;
    return (m > z) ? m : z;
  endfunction

  // Bits needed to hold 0..maxv without wrapping.
  function automatic int cnt_width(input int maxv);
    return (maxv <= 1) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// sclk divider: toggles every CLK_DIV clk cycles while enabled, held low otherwise.
// rise/fall mark the clk cycle whose closing edge moves sclk.
module spi_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  logic [DW-1:0] div_cnt_r;
  logic          sclk_r;
  logic          tick_s;

  // Toggle strobes for the current cycle.
  always_comb begin
    tick_s = en && (div_cnt_r == DIV_LAST);
    rise   = tick_s && !sclk_r;
    fall   = tick_s && sclk_r;
  end

  // Divider counter and serial clock register.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r <= '0;
      sclk_r    <= 1'b0;
    end else if (!en) begin
      div_cnt_r <= '0;
      sclk_r    <= 1'b0;
    end else if (tick_s) begin
      div_cnt_r <= '0;
      sclk_r    <= ~sclk_r;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_ONE;
    end
  end

  assign sclk = sclk_r;

endmodule

// File: rtl/spi_mult_master.sv
// SPI master framing one multiply transaction: lead-in, operand shift-out,
// multiply gap, product shift-in, then a one-cycle done pulse.
module spi_mult_master
  import spi_mult_master_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int CLK_DIV     = 2,
  parameter int LEAD_CYCLES = 1,
  parameter int GAP_CYCLES  = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               sclk,
  output logic               cs,
  output logic               mosi,
  input  logic               miso
);

  localparam int FW = 2 * WIDTH;
  localparam int CW = cnt_width(max3(LEAD_CYCLES, GAP_CYCLES, FW));
  localparam logic [CW-1:0] LEAD_LAST  = CW'(LEAD_CYCLES);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FW);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_t          state_r;
  logic [FW-1:0]   tx_r;
  logic [FW-1:0]   rx_r;
  logic [FW-1:0]   result_r;
  logic [CW-1:0]   cnt_r;
  logic            cs_r;
  logic            mosi_r;
  logic            busy_r;
  logic            done_r;
  logic            clk_en_s;
  logic            rise_s;
  logic            fall_s;
  logic            sclk_s;

  // sclk runs only while the frame is on the wire.
  always_comb begin
    clk_en_s = (state_r != ST_IDLE) && (state_r != ST_DONE);
  end

  spi_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk  (clk),
    .reset(reset),
    .en   (clk_en_s),
    .sclk (sclk_s),
    .rise (rise_s),
    .fall (fall_s)
  );

  // Transaction FSM; phase changes happen on sclk falls so sclk ends each phase low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      tx_r     <= '0;
      rx_r     <= '0;
      result_r <= '0;
      cnt_r    <= '0;
      cs_r     <= 1'b0;
      mosi_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req) begin
            tx_r    <= {a, b};
            rx_r    <= '0;
            cnt_r   <= '0;
            cs_r    <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (rise_s) begin
            cnt_r <= cnt_r + CNT_ONE;
          end else if (fall_s && (cnt_r == LEAD_LAST)) begin
            mosi_r  <= tx_r[FW-1];
            cnt_r   <= '0;
            state_r <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (rise_s) begin
            cnt_r <= cnt_r + CNT_ONE;
          end else if (fall_s) begin
            if (cnt_r == FRAME_LAST) begin
              mosi_r  <= 1'b0;
              cnt_r   <= '0;
              state_r <= (GAP_CYCLES == 0) ? ST_RECV : ST_GAP;
            end else begin
              mosi_r <= tx_r[FW-2];
              tx_r   <= {tx_r[FW-2:0], 1'b0};
            end
          end
        end
        ST_GAP: begin
          if (rise_s) begin
            cnt_r <= cnt_r + CNT_ONE;
          end else if (fall_s && (cnt_r == GAP_LAST)) begin
            cnt_r   <= '0;
            state_r <= ST_RECV;
          end
        end
        ST_RECV: begin
          // Product arrives MSB first, sampled on the rise.
          if (rise_s) begin
            rx_r  <= {rx_r[FW-2:0], miso};
            cnt_r <= cnt_r + CNT_ONE;
          end else if (fall_s && (cnt_r == FRAME_LAST)) begin
            cs_r    <= 1'b0;
            cnt_r   <= '0;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          result_r <= rx_r;
          done_r   <= 1'b1;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          cs_r    <= 1'b0;
          mosi_r  <= 1'b0;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign sclk   = sclk_s;
  assign cs     = cs_r;
  assign mosi   = mosi_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_spi_mult_master.sv
// Bench for spi_mult_master: two configurations checked every cycle against a
// closed-form timing model, with a pin-level multiplier peripheral on miso.
module tb_spi_mult_master;

  localparam int W  = 4;
  localparam int FW = 8;
  localparam int L  = 1;

  logic             clk;
  logic             reset;
  logic             req;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             busy_o   [2];
  logic             done_o   [2];
  logic             sclk_o   [2];
  logic             cs_o     [2];
  logic             mosi_o   [2];
  logic             miso_i   [2];
  logic [FW-1:0]    result_o [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_mult_master #(.WIDTH(4), .CLK_DIV(2), .LEAD_CYCLES(1), .GAP_CYCLES(12)) dut0 (
    .clk(clk), .reset(reset), .req(req), .a(a), .b(b),
    .busy(busy_o[0]), .done(done_o[0]), .result(result_o[0]),
    .sclk(sclk_o[0]), .cs(cs_o[0]), .mosi(mosi_o[0]), .miso(miso_i[0])
  );

  spi_mult_master #(.WIDTH(4), .CLK_DIV(1), .LEAD_CYCLES(1), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .req(req), .a(a), .b(b),
    .busy(busy_o[1]), .done(done_o[1]), .result(result_o[1]),
    .sclk(sclk_o[1]), .cs(cs_o[1]), .mosi(mosi_o[1]), .miso(miso_i[1])
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Transaction model state
  bit            act     [2];
  int            t       [2];
  logic [W-1:0]  opa     [2];
  logic [W-1:0]  opb     [2];
  logic [FW-1:0] res_m   [2];
  bit            done_m  [2];
  int            acc_cyc [2];
  int            done_cyc[2];
  int            n_done  [2];

  // Peripheral state
  int            rcnt     [2];
  logic [FW-1:0] prx      [2];
  logic          prev_sclk[2];
  logic          prev_cs  [2];
  logic [31:0]   rlog0;
  int            rn0;
  logic [31:0]   last_log0;
  int            last_n0;

  function automatic int cdv(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int gapv(input int d);
    return (d == 0) ? 12 : 0;
  endfunction

  function automatic int periods(input int d);
    return L + FW + gapv(d) + FW;
  endfunction

  task automatic chk(input string nm, input int d, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, d, cyc, got, want);
    end
  endtask

  task automatic tick();
    logic          req_p, rst_p;
    logic [W-1:0]  a_p, b_p;
    int            cd, tt, p, base, j;
    logic [FW-1:0] fr, prod;
    logic          e_cs, e_sclk, e_mosi, e_busy, e_done;
    req_p = req;
    rst_p = reset;
    a_p   = a;
    b_p   = b;
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      cd = cdv(d);
      tt = 2 * cd * periods(d);
      if (rst_p) begin
        act[d]    = 1'b0;
        t[d]      = 0;
        res_m[d]  = '0;
        done_m[d] = 1'b0;
      end else begin
        done_m[d] = 1'b0;
        if (act[d]) begin
          t[d]++;
          if (t[d] == tt + 1) begin
            act[d]    = 1'b0;
            done_m[d] = 1'b1;
            res_m[d]  = 8'(opa[d]) * 8'(opb[d]);
          end
        end else if (req_p) begin
          act[d]     = 1'b1;
          t[d]       = 0;
          opa[d]     = a_p;
          opb[d]     = b_p;
          acc_cyc[d] = cyc;
        end
      end
      e_cs = 1'b0; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      if (act[d]) begin
        e_busy = 1'b1;
        if (t[d] < tt) begin
          e_cs   = 1'b1;
          e_sclk = ((t[d] / cd) % 2) == 1;
          p      = t[d] / (2 * cd);
          fr     = {opa[d], opb[d]};
          if (p >= L && p < L + FW) e_mosi = fr[FW - 1 - (p - L)];
        end
      end else begin
        e_done = done_m[d];
      end
      chk("cs",     d, {7'b0, cs_o[d]},   {7'b0, e_cs});
      chk("sclk",   d, {7'b0, sclk_o[d]}, {7'b0, e_sclk});
      chk("mosi",   d, {7'b0, mosi_o[d]}, {7'b0, e_mosi});
      chk("busy",   d, {7'b0, busy_o[d]}, {7'b0, e_busy});
      chk("done",   d, {7'b0, done_o[d]}, {7'b0, e_done});
      chk("result", d, result_o[d], res_m[d]);
      if (done_o[d] === 1'b1) begin
        n_done[d]++;
        done_cyc[d] = cyc;
      end
      // Peripheral: decodes operands from mosi, returns the product on miso.
      if (d == 0 && prev_cs[0] === 1'b1 && cs_o[0] !== 1'b1) begin
        last_log0 = rlog0;
        last_n0   = rn0;
      end
      if (cs_o[d] !== 1'b1) begin
        rcnt[d]   = 0;
        prx[d]    = '0;
        miso_i[d] = 1'b0;
        if (d == 0) begin
          rlog0 = '0;
          rn0   = 0;
        end
      end else if (prev_sclk[d] === 1'b0 && sclk_o[d] === 1'b1) begin
        rcnt[d]++;
        if (rcnt[d] > L && rcnt[d] <= L + FW) prx[d] = {prx[d][FW-2:0], mosi_o[d]};
        if (d == 0) begin
          rlog0 = {rlog0[30:0], mosi_o[0]};
          rn0++;
        end
      end else if (prev_sclk[d] === 1'b1 && sclk_o[d] === 1'b0) begin
        base = L + FW + gapv(d);
        if (rcnt[d] >= base && rcnt[d] < base + FW) begin
          j         = rcnt[d] - base;
          prod      = 8'(prx[d][7:4]) * 8'(prx[d][3:0]);
          miso_i[d] = prod[FW - 1 - j];
        end else begin
          miso_i[d] = 1'b0;
        end
      end
      prev_sclk[d] = sclk_o[d];
      prev_cs[d]   = cs_o[d];
    end
  endtask

  task automatic wait_done(input int d, input int limit);
    int n0;
    bit seen;
    n0   = n_done[d];
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (n_done[d] != n0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout dut%0d got=no done in %0d cycles want=done pulse", d, limit);
    end
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && (act[0] || act[1]); i++) tick();
    checks++;
    if (act[0] || act[1]) begin
      errors++;
      $display("FAIL idle_timeout got=still active want=idle within %0d cycles", limit);
    end
  endtask

  initial begin
    int nb;
    bit hit;
    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0; t[d] = 0; res_m[d] = '0; done_m[d] = 1'b0;
      n_done[d] = 0; acc_cyc[d] = 0; done_cyc[d] = 0;
      rcnt[d] = 0; prx[d] = '0; prev_sclk[d] = 1'b0; prev_cs[d] = 1'b0;
      miso_i[d] = 1'b0;
    end
    rlog0 = '0; rn0 = 0; last_log0 = '0; last_n0 = 0;
    reset = 1'b1; req = 1'b0; a = '0; b = '0;

    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_cs",     d, {7'b0, cs_o[d]},   8'h00);
      chk("rst_sclk",   d, {7'b0, sclk_o[d]}, 8'h00);
      chk("rst_busy",   d, {7'b0, busy_o[d]}, 8'h00);
      chk("rst_result", d, result_o[d],       8'h00);
    end
    reset = 1'b0;
    tick();

    // a=3, b=5 with a single-cycle req
    a = 4'd3; b = 4'd5; req = 1'b1;
    tick();
    req = 1'b0;
    chk("t1_cs_next", 0, {7'b0, cs_o[0]}, 8'h01);
    wait_done(0, 300);
    chk("t1_latency",  0, 8'(done_cyc[0] - acc_cyc[0]), 8'd117);
    chk("t1_result",   0, result_o[0], 8'h0F);
    chk("t1_rises",    0, 8'(last_n0), 8'd29);
    chk("t1_lead_bit", 0, {7'b0, last_log0[28]}, 8'h00);
    chk("t1_mosi",     0, last_log0[27:20], 8'h35);
    chk("t1_latency",  1, 8'(done_cyc[1] - acc_cyc[1]), 8'd35);
    chk("t1_result",   1, result_o[1], 8'h0F);
    tick();
    chk("t1_done_pulse", 0, {7'b0, done_o[0]}, 8'h00);
    wait_idle(200);

    // req held high: one transaction, next starts right after DONE
    a = 4'd7; b = 4'd7; req = 1'b1;
    nb = n_done[0];
    wait_done(0, 300);
    tick();
    chk("hold_second_start", 0, {7'b0, cs_o[0]}, 8'h01);
    chk("hold_one_done",     0, 8'(n_done[0] - nb), 8'd1);
    chk("hold_mosi",         0, last_log0[27:20], 8'h77);
    chk("hold_result",       0, result_o[0], 8'h31);
    req = 1'b0;
    wait_done(0, 300);
    chk("hold_result2", 0, result_o[0], 8'h31);
    wait_idle(200);

    // reset during SEND (4th data rise = 5th rise overall)
    a = 4'd9; b = 4'd6; req = 1'b1;
    tick();
    req = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      if (rcnt[0] == 5) hit = 1'b1;
    end
    chk("rst_mid_reach", 0, {7'b0, hit}, 8'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_cs",     0, {7'b0, cs_o[0]},   8'h00);
    chk("rst_mid_sclk",   0, {7'b0, sclk_o[0]}, 8'h00);
    chk("rst_mid_busy",   0, {7'b0, busy_o[0]}, 8'h00);
    chk("rst_mid_result", 0, result_o[0],       8'h00);
    nb = n_done[0];
    repeat (150) tick();
    chk("rst_mid_no_done", 0, 8'(n_done[0] - nb), 8'd0);

    // randomized traffic, including req while busy and occasional reset
    for (int i = 0; i < 3000; i++) begin
      req   = ($urandom_range(0, 5) == 0);
      a     = 4'($urandom);
      b     = 4'($urandom);
      reset = ($urandom_range(0, 699) == 0);
      tick();
    end
    reset = 1'b0;
    req   = 1'b0;
    wait_idle(400);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
